// File: rtl/morse_decoder_fifo.sv
// Straight-key Morse decoder with an Avalon-MM register interface.
// Debounced key marks and spaces are timed, decoded to ASCII and queued for software.
module morse_decoder_fifo #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DOT_DEFAULT = 25_000_000,
  parameter int unsigned GAP_DEFAULT = 50_000_000,
  parameter int unsigned DEBOUNCE    = 1_000,
  parameter int unsigned MAX_LEN     = 6,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        key_n,
  output logic [7:0]  ascii_out,
  output logic        busy
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, COMMIT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   timer_q, dot_q, gap_q;
  logic [MAX_LEN-1:0] code_q;
  logic [LEN_W-1:0]   len_q;
  logic               len_err_q, len_err_st_q, ovf_q, ovf_d;
  logic               ctrl_en_q, ctrl_irq_en_q, ctrl_irq_en_d;
  logic               key_s1_q, key_s2_q, key_db_q;
  logic [DB_W-1:0]    db_cnt_q;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [31:0]        readdata_q, rdata_c;
  logic [7:0]         ascii_q, push_data_c;
  logic               irq_q, busy_q;
  logic               pressed, push_c, pop_c, do_push, fifo_clr, fifo_empty, fifo_full;
  logic               wr_ctrl, wr_status, len_ovf_c, unused_c;

  // ITU letters (len 1..4) and digits (len 5); first element is the MSB of the code
  function automatic logic [7:0] lookup(input logic [LEN_W-1:0] len, input logic [4:0] c);
    logic [7:0] ch;
    ch = 8'h5F;
    case (32'(len))
      1: ch = c[0] ? "T" : "E";
      2: case (c[1:0])
           2'b00: ch = "I"; 2'b01: ch = "A"; 2'b10: ch = "N"; default: ch = "M";
         endcase
      3: case (c[2:0])
           3'b000: ch = "S"; 3'b001: ch = "U"; 3'b010: ch = "R"; 3'b011: ch = "W";
           3'b100: ch = "D"; 3'b101: ch = "K"; 3'b110: ch = "G"; default: ch = "O";
         endcase
      4: case (c[3:0])
           4'b0000: ch = "H"; 4'b0001: ch = "V"; 4'b0010: ch = "F"; 4'b0100: ch = "L";
           4'b0110: ch = "P"; 4'b0111: ch = "J"; 4'b1000: ch = "B"; 4'b1001: ch = "X";
           4'b1010: ch = "C"; 4'b1011: ch = "Y"; 4'b1100: ch = "Z"; 4'b1101: ch = "Q";
           default: ch = 8'h5F;
         endcase
      5: case (c)
           5'b01111: ch = "1"; 5'b00111: ch = "2"; 5'b00011: ch = "3"; 5'b00001: ch = "4";
           5'b00000: ch = "5"; 5'b10000: ch = "6"; 5'b11000: ch = "7"; 5'b11100: ch = "8";
           5'b11110: ch = "9"; 5'b11111: ch = "0"; default: ch = 8'h5F;
         endcase
      default: ch = 8'h5F;
    endcase
    return ch;
  endfunction

  assign wr_ctrl    = write && (address == 3'd0);
  assign wr_status  = write && (address == 3'd1);
  assign fifo_clr   = wr_ctrl && writedata[1];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop_c      = read && (address == 3'd2) && !fifo_empty;
  assign pressed    = !key_db_q;
  assign push_c     = ctrl_en_q && (state_q == COMMIT);
  assign push_data_c = len_err_q ? 8'h5F : lookup(len_q, 5'(code_q));
  assign len_ovf_c  = ctrl_en_q && (state_q == MARK) && !pressed && (len_q == LEN_W'(MAX_LEN));
  assign ctrl_irq_en_d = wr_ctrl ? writedata[2] : ctrl_irq_en_q;
  assign unused_c   = ^{writedata, code_q};

  // Synchroniser plus debounce: accept a new level after DEBOUNCE differing samples in a row
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      key_db_q <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      if (key_s2_q == key_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
        key_db_q <= key_s2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      code_q    <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
      busy_q    <= 1'b0;
      ascii_q   <= 8'h00;
    end else if (!ctrl_en_q) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      code_q    <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pressed) begin
          state_q <= MARK;
          timer_q <= '0;
          busy_q  <= 1'b1;
        end
        MARK: if (!pressed) begin
          if (len_q == LEN_W'(MAX_LEN)) begin
            len_err_q <= 1'b1;
          end else begin
            code_q <= {code_q[MAX_LEN-2:0], timer_q >= dot_q};
            len_q  <= len_q + LEN_W'(1);
          end
          state_q <= SPACE;
          timer_q <= '0;
        end else if (timer_q != '1) begin
          timer_q <= timer_q + CNT_W'(1);
        end
        SPACE: if (pressed) begin
          state_q <= MARK;
          timer_q <= '0;
        end else if (timer_q >= gap_q) begin
          state_q <= COMMIT;
        end else if (timer_q != '1) begin
          timer_q <= timer_q + CNT_W'(1);
        end
        default: begin
          ascii_q   <= push_data_c;
          code_q    <= '0;
          len_q     <= '0;
          len_err_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointer/count next state; clear beats push, a full FIFO accepts push only alongside a pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    do_push  = 1'b0;
    if (wr_status && writedata[2]) ovf_d = 1'b0;
    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_c && (!fifo_full || pop_c)) begin
        do_push  = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (push_c && fifo_full && !pop_c) ovf_d = 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_c;
  end

  always_comb begin
    rdata_c = 32'h0;
    case (address)
      3'd0: rdata_c = {29'h0, ctrl_irq_en_q, 1'b0, ctrl_en_q};
      3'd1: rdata_c = {16'h0, 8'(count_q), 4'h0, len_err_st_q, ovf_q, fifo_full, fifo_empty};
      3'd2: rdata_c = fifo_empty ? 32'h0 : {24'h0, mem_q[rd_ptr_q]};
      3'd3: rdata_c = 32'(dot_q);
      3'd4: rdata_c = 32'(gap_q);
      default: rdata_c = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      ctrl_en_q     <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      dot_q         <= CNT_W'(DOT_DEFAULT);
      gap_q         <= CNT_W'(GAP_DEFAULT);
      len_err_st_q  <= 1'b0;
      readdata_q    <= 32'h0;
      irq_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      ctrl_irq_en_q <= ctrl_irq_en_d;
      irq_q         <= ctrl_irq_en_d && (count_d != '0);
      if (wr_ctrl) ctrl_en_q <= writedata[0];
      if (write && (address == 3'd3)) dot_q <= writedata[CNT_W-1:0];
      if (write && (address == 3'd4)) gap_q <= writedata[CNT_W-1:0];
      if (len_ovf_c) len_err_st_q <= 1'b1;
      else if (wr_status && writedata[3]) len_err_st_q <= 1'b0;
      if (read) readdata_q <= rdata_c;
    end
  end

  assign readdata  = readdata_q;
  assign irq       = irq_q;
  assign ascii_out = ascii_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_morse_decoder_fifo.sv
// Directed bench for morse_decoder_fifo: short thresholds and debounce so characters decode in tens of cycles.
module tb_morse_decoder_fifo;
  logic        clk = 1'b0;
  logic        reset, read, write, key_n, irq, busy;
  logic [2:0]  address;
  logic [31:0] writedata, readdata, rd;
  logic [7:0]  ascii_out;
  int          n_cmp = 0;
  int          n_err = 0;

  morse_decoder_fifo #(.DEBOUNCE(2), .MAX_LEN(6), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq), .key_n(key_n),
    .ascii_out(ascii_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic press(input int n);
    @(negedge clk);
    key_n = 1'b0;
    repeat (n) @(negedge clk);
    key_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
  endtask

  task automatic configure();
    bus_write(3'd3, 32'd10);
    bus_write(3'd4, 32'd40);
    bus_write(3'd0, 32'h5);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata got %h want 0", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
    n_cmp++; if (ascii_out !== 8'h00) begin n_err++; $display("FAIL reset_ascii got %h want 00", ascii_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL reset_status got %h want 00000001", rd); end
    bus_read(3'd0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", rd); end
    bus_read(3'd3, rd);
    n_cmp++; if (rd !== 32'd25_000_000) begin n_err++; $display("FAIL reset_dot got %0d want 25000000", rd); end
    bus_read(3'd4, rd);
    n_cmp++; if (rd !== 32'd50_000_000) begin n_err++; $display("FAIL reset_gap got %0d want 50000000", rd); end
    bus_read(3'd6, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reg6_read got %h want 0", rd); end
  endtask

  task automatic test_letter_e();
    press(5);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL e_busy got %b want 1", busy); end
    idle(60);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL e_busy_end got %b want 0", busy); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL e_irq got %b want 1", irq); end
    n_cmp++; if (ascii_out !== 8'h45) begin n_err++; $display("FAIL e_ascii got %h want 45", ascii_out); end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h0100) begin n_err++; $display("FAIL e_status got %h want 00000100", rd); end
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 32'h45) begin n_err++; $display("FAIL e_data got %h want 45", rd); end
    idle(1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL e_irq_drain got %b want 0", irq); end
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL e_data_empty got %h want 0", rd); end
  endtask

  task automatic test_letter_d();
    press(20); idle(10);
    press(5);  idle(10);
    press(5);  idle(60);
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 32'h44) begin n_err++; $display("FAIL d_data got %h want 44", rd); end
  endtask

  task automatic test_len_err();
    for (int i = 0; i < 7; i++) begin
      press(5); idle(10);
    end
    idle(60);
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 32'h5F) begin n_err++; $display("FAIL lenerr_data got %h want 5f", rd); end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h9) begin n_err++; $display("FAIL lenerr_status got %h want 00000009", rd); end
    bus_write(3'd1, 32'h08);
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL lenerr_clear got %h want 00000001", rd); end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] exp;
    for (int i = 0; i < 9; i++) begin
      press((i % 2 == 1) ? 20 : 5);
      idle(60);
    end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h0806) begin n_err++; $display("FAIL ovf_status got %h want 00000806", rd); end
    for (int i = 0; i < 8; i++) begin
      exp = (i % 2 == 1) ? 8'h54 : 8'h45;
      bus_read(3'd2, rd);
      n_cmp++; if (rd !== {24'h0, exp}) begin n_err++; $display("FAIL ovf_data%0d got %h want %h", i, rd, exp); end
    end
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ovf_data8 got %h want 0", rd); end
    bus_write(3'd1, 32'h04);
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL ovf_clear got %h want 00000001", rd); end
  endtask

  task automatic test_fifo_clr();
    press(5); idle(60);
    bus_write(3'd0, 32'h7);
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL clr_status got %h want 00000001", rd); end
    bus_read(3'd0, rd);
    n_cmp++; if (rd !== 32'h5) begin n_err++; $display("FAIL clr_selfclear got %h want 00000005", rd); end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    key_n = 1'b0;
    @(negedge clk);
    key_n = 1'b1;
    idle(60);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy got %b want 0", busy); end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL glitch_status got %h want 00000001", rd); end
  endtask

  task automatic test_dot_thresh();
    bus_write(3'd3, 32'd30);
    press(20); idle(60);
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 32'h45) begin n_err++; $display("FAIL dot30_data got %h want 45", rd); end
  endtask

  task automatic test_reset_mid_mark();
    press(5); idle(60);
    @(negedge clk);
    key_n = 1'b0;
    idle(10);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midmark_busy got %b want 1", busy); end
    do_reset();
    key_n = 1'b1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midmark_busy_rst got %b want 0", busy); end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL midmark_status got %h want 00000001", rd); end
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; key_n = 1'b1;
    address = 3'd0; writedata = 32'h0;
    test_reset();
    configure();
    test_letter_e();
    test_letter_d();
    test_len_err();
    test_fifo_overflow();
    test_fifo_clr();
    test_glitch();
    test_dot_thresh();
    test_reset_mid_mark();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
